// File: rtl/recibo_rx_pkg.sv
// recibo_rx_pkg: shared types and defaults for the recibo_rx serial receiver.
//   rx_state_t        - receiver FSM states
//   DEF_CLKS_PER_BIT  - default clock cycles per serial bit
//   DEF_DATA_BITS     - default data bits per frame
package recibo_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 10400;
    localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/recibo_rx_baud.sv
// recibo_rx_baud: bit-period counter for the serial receiver.
// Counts 0..CLKS_PER_BIT-1 and wraps; a synchronous clear restarts it.
//   clk, reset   - clock, synchronous active-high reset
//   clr_i        - restart the count at 0 on the next edge
//   half_o       - high in the last cycle of a half bit period since clear
//   full_o       - high in the last cycle of each full bit period
module recibo_rx_baud
    import recibo_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic half_o,
    output logic full_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign half_o = (cnt_q == HALF_M1);
    assign full_o = (cnt_q == FULL_M1);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || full_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/recibo_rx.sv
// recibo_rx: 8N1 (LSB first) asynchronous serial receiver.
// Detects a low start level while enabled, checks it at half a bit period,
// samples each data bit at its centre and delivers the byte with a one-cycle
// strobe and a framing-error flag.
//   clk        - system clock
//   reset      - synchronous active-high reset
//   rw         - receive enable, gates only the start of a frame
//   Rx         - serial line, idle high
//   busy       - high while a frame is in progress (FSM not IDLE)
//   data       - last received byte, held until the next frame completes
//   done       - one-cycle strobe when data/frame_err update
//   frame_err  - stop bit of the last frame was sampled low
// Optional macro RECIBO_RX_SYNC_EN: Rx goes through a 2-flop synchronizer
// (flops reset to 1), shifting every sample instant by +2 cycles.
module recibo_rx
    import recibo_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rw,
    input  logic                 Rx,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 frame_err
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;
    logic                 half, full, baud_clr;

`ifdef RECIBO_RX_SYNC_EN
    // Flops reset high so a reset never looks like a start bit.
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], Rx};
        end
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = Rx;
`endif

    // Counter is held at 0 in IDLE and restarts on every state change, so the
    // half tick in START lands CLKS_PER_BIT/2 cycles after start detection and
    // each full tick lands one bit period after the previous sample.
    assign baud_clr = (state_q == IDLE) || (state_d != state_q);

    recibo_rx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (baud_clr),
        .half_o (half),
        .full_o (full)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                // Level detect: a late enable in the middle of a start bit
                // still catches the frame.
                if (rw && !rx_s) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                if (half) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (full) begin
                    data_d  = shift_q;
                    done_d  = 1'b1;
                    ferr_d  = ~rx_s;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high so a stuck-low line
                // cannot retrigger a frame.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign data      = data_q;
    assign done      = done_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_recibo_rx.sv
// tb_recibo_rx: self-checking bench for recibo_rx with a short bit period.
// A timing model derives every sample instant from the start-detection edge
// with plain arithmetic and predicts busy/done/data/frame_err each cycle.
module tb_recibo_rx;
    localparam int C  = 16;
    localparam int H  = C / 2;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rw = 1'b0;
    logic          Rx = 1'b0;
    logic          busy, done, frame_err;
    logic [DB-1:0] data;

    recibo_rx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rw        (rw),
        .Rx        (Rx),
        .busy      (busy),
        .data      (data),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [DB-1:0] got_q[$];

    // ---------------- model ----------------
    int            m_t0 = -1;
    bit            m_wait = 0, m_busy = 0, m_done = 0, m_ferr = 0;
    logic [DB-1:0] m_data = '0, m_byte = '0;
    bit            s1 = 1, s2 = 1;

    task automatic model_step();
        bit rxs;
        int rel, k;
`ifdef RECIBO_RX_SYNC_EN
        rxs = s2;
        if (reset) begin s1 = 1; s2 = 1; end
        else begin s2 = s1; s1 = Rx; end
`else
        rxs = Rx;
`endif
        m_done = 0;
        if (reset) begin
            m_t0 = -1; m_wait = 0; m_data = '0; m_ferr = 0;
        end else if (m_wait) begin
            if (rxs) m_wait = 0;
        end else if (m_t0 < 0) begin
            if (rw && !rxs) m_t0 = cyc;
        end else begin
            rel = cyc - m_t0;
            if (rel == H && rxs) begin
                m_t0 = -1;
            end else if (rel > H && (rel - H) % C == 0) begin
                k = (rel - H) / C - 1;
                if (k < DB) m_byte[k] = rxs;
                else begin
                    m_data = m_byte; m_ferr = !rxs; m_done = 1;
                    m_t0 = -1; m_wait = !rxs;
                end
            end
        end
        m_busy = (m_t0 >= 0) || m_wait;
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare ----------------
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            n_cmp++;
            if (busy !== m_busy || done !== m_done || data !== m_data || frame_err !== m_ferr) begin
                n_bad++;
                $display("FAIL cycle %0d outputs busy/done/data/ferr: got %b/%b/%h/%b want %b/%b/%h/%b",
                         cyc, busy, done, data, frame_err, m_busy, m_done, m_data, m_ferr);
            end
            if (done === 1'b1) begin
                done_cnt++;
                got_q.push_back(data);
            end
            if (busy === 1'b1) busy_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input bit stopb, input int idle, input bit drop);
        Rx = 1'b0; tick(C);
        if (drop) rw = 1'b0;
        for (int i = 0; i < DB; i++) begin
            Rx = b[i]; tick(C);
        end
        Rx = stopb; tick(C);
        Rx = 1'b1; tick(idle);
        rw = 1'b1;
    endtask

    initial begin : main
        int d0;
        logic [DB-1:0] v;
        int kind;
        logic [DB-1:0] b;
        bit sb;

        // reset with the line low
        reset = 1'b1; Rx = 1'b0; rw = 1'b0;
        tick(50);
        chk("reset_busy", busy, 0);
        chk("reset_data", data, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_no_done", done_cnt, 0);
        reset = 1'b0; Rx = 1'b1; rw = 1'b1;
        tick(2 * C);

        // clean frame 0x6A
        busy_cnt = 0; d0 = done_cnt;
        send_frame(8'h6A, 1'b1, 2 * C, 1'b0);
        chk("f1_done_count", done_cnt - d0, 1);
        chk("f1_data", data, 'h6A);
        chk("f1_ferr", frame_err, 0);
        chk("f1_busy_cycles", busy_cnt, 152);

        // late enable, stop bit low, line stays low
        d0 = done_cnt;
        rw = 1'b0; Rx = 1'b0; tick(3);
        rw = 1'b1; tick(C - 3);
        v = 8'h6A;
        for (int i = 0; i < DB; i++) begin
            Rx = v[i]; tick(C);
        end
        Rx = 1'b0; tick(3 * C);
        chk("f2_done_count", done_cnt - d0, 1);
        chk("f2_data", data, 'h6A);
        chk("f2_ferr", frame_err, 1);
        chk("f2_busy_stuck_low", busy, 1);
        Rx = 1'b1; tick(4);
        chk("f2_busy_released", busy, 0);
        tick(C);

        // short glitch on an idle line
        busy_cnt = 0; d0 = done_cnt;
        Rx = 1'b0; tick(5);
        Rx = 1'b1; tick(2 * C);
        chk("glitch_busy_cycles", busy_cnt, 8);
        chk("glitch_no_done", done_cnt - d0, 0);

        // back-to-back frames
        got_q.delete();
        send_frame(8'h55, 1'b1, 0, 1'b0);
        send_frame(8'hA3, 1'b1, 2 * C, 1'b0);
        chk("b2b_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("b2b_first", got_q[0], 'h55);
            chk("b2b_second", got_q[1], 'hA3);
        end

        // reset in the middle of DATA
        d0 = done_cnt;
        v = 8'h3C;
        Rx = 1'b0; tick(C);
        for (int i = 0; i < 3; i++) begin
            Rx = v[i]; tick(C);
        end
        reset = 1'b1; Rx = 1'b1; tick(1);
        chk("midreset_busy", busy, 0);
        reset = 1'b0; tick(2 * C);
        chk("midreset_no_done", done_cnt - d0, 0);
        got_q.delete();
        send_frame(8'h3C, 1'b1, 2 * C, 1'b0);
        chk("after_reset_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("after_reset_data", got_q[0], 'h3C);

        // randomized traffic, checked cycle by cycle against the model
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            b    = DB'($urandom);
            sb   = ($urandom_range(0, 4) != 0);
            if (kind < 2) begin
                Rx = 1'b0; tick($urandom_range(1, C));
                Rx = 1'b1; tick(C + $urandom_range(0, C));
            end else if (kind == 2) begin
                send_frame(b, sb, $urandom_range(1, C), 1'b1);
            end else if (kind == 3) begin
                rw = 1'b0;
                send_frame(b, sb, $urandom_range(1, C), 1'b0);
            end else if (kind == 4) begin
                Rx = 1'b1; rw = 1'b0; tick($urandom_range(1, C));
                Rx = 1'b0; tick($urandom_range(1, H - 1));
                rw = 1'b1; tick($urandom_range(C, 12 * C));
                Rx = 1'b1; tick(12 * C);
            end else begin
                send_frame(b, sb, $urandom_range(1, C), 1'b0);
            end
        end
        Rx = 1'b1; rw = 1'b1; tick(12 * C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
